// File: rtl/sb_pkg.sv
// Shared types and defaults for the sideband transmit serializer.
package sb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } sb_ser_state_t;

  localparam int                    SB_WIDTH     = 8;
  localparam logic [SB_WIDTH-1:0]   SB_IDLE_WORD = '0;

endpackage

// File: rtl/sb_serializer_if.sv
// Word handshake between the sideband generator (master) and the serializer (slave).
interface sb_serializer_if
  import sb_pkg::*;
#(
  parameter int WIDTH = SB_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/sb_tx_hold.sv
// One-entry holding buffer in front of the shift register, with bypass on load
// and replace-while-loading so one word can be taken every frame boundary.
module sb_tx_hold
  import sb_pkg::*;
#(
  parameter int               WIDTH     = SB_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [WIDTH-1:0] next_word,
  output logic             next_fill
);

  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             accept;
  logic             bypass;

  assign data_ready = !hold_full || load;
  assign accept     = data_valid && data_ready;
  assign bypass     = load && !hold_full && data_valid;

  always_comb begin
    next_word = IDLE_WORD;
    next_fill = 1'b0;
    if (hold_full) begin
      next_word = hold;
    end else if (data_valid) begin
      next_word = data_in;
    end else begin
      next_fill = 1'b1;
    end
  end

  // A word accepted while the held one is being loaded takes its place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept && !bypass) begin
      hold      <= data_in;
      hold_full <= 1'b1;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/sb_serializer.sv
// Sideband TX serializer: WIDTH-bit words out LSB first in contiguous frames,
// idle-word fill when no data is available at a frame boundary.
//   state  | meaning
//   IDLE   | line held at 0, waiting for tx_enable
//   ACTIVE | shifting a frame, cnt = bit index on serial_out
module sb_serializer
  import sb_pkg::*;
#(
  parameter int               WIDTH     = SB_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_enable,
  sb_serializer_if.slave       bus,
  output logic                 serial_out,
  output logic                 frame_start,
  output logic                 idle_fill,
  output logic                 busy
);

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
  localparam logic [0:0]      ST_IDLE   = IDLE;
  localparam logic [0:0]      ST_ACTIVE = ACTIVE;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             fill;
  logic             load;
  logic [WIDTH-1:0] next_word;
  logic             next_fill;

  assign load = tx_enable && ((state == ST_IDLE) || (cnt == LAST));

  sb_tx_hold #(
    .WIDTH     (WIDTH),
    .IDLE_WORD (IDLE_WORD)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (bus.data_in),
    .data_valid (bus.data_valid),
    .data_ready (bus.data_ready),
    .next_word  (next_word),
    .next_fill  (next_fill)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
    end else if (load) begin
      state <= ST_ACTIVE;
      shreg <= next_word;
      cnt   <= '0;
      fill  <= next_fill;
    end else if (state == ST_ACTIVE) begin
      if (cnt == LAST) begin
        state <= ST_IDLE;
        shreg <= '0;
        cnt   <= '0;
        fill  <= 1'b0;
      end else begin
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign serial_out  = shreg[0];
  assign busy        = (state == ST_ACTIVE);
  assign frame_start = busy && (cnt == '0);
  assign idle_fill   = busy && fill;

endmodule

// File: tb/tb_sb_serializer.sv
// Directed bench for sb_serializer: one table vector per clock, plus a hand
// sequence for asynchronous reset in the middle of a frame.
module tb_sb_serializer;

  logic clk;
  logic rst;
  logic tx_enable;
  logic serial_out;
  logic frame_start;
  logic idle_fill;
  logic busy;

  int n_total  = 0;
  int n_passed = 0;

  sb_serializer_if #(.WIDTH(8)) bus ();

  sb_serializer #(
    .WIDTH     (8),
    .IDLE_WORD (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_enable   (tx_enable),
    .bus         (bus),
    .serial_out  (serial_out),
    .frame_start (frame_start),
    .idle_fill   (idle_fill),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       te;
    logic       v;
    logic [7:0] d;
    logic       so;
    logic       fs;
    logic       ifl;
    logic       bs;
    logic       rdy;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    else
      n_passed++;
  endtask

  task automatic add(input logic te, v, input logic [7:0] d,
                     input logic so, fs, ifl, bs, rdy);
    vec_t e;
    e.te = te; e.v = v; e.d = d;
    e.so = so; e.fs = fs; e.ifl = ifl; e.bs = bs; e.rdy = rdy;
    vq.push_back(e);
  endtask

  // Expected outputs while bits k0..k1 of word w are on the line.
  task automatic add_bits(input logic te, v, input logic [7:0] d,
                          input logic [7:0] w, input int k0, k1,
                          input logic fl, rdy);
    for (int k = k0; k <= k1; k++)
      add(te, v, d, w[k], (k == 0), fl, 1'b1, rdy);
  endtask

  task automatic check_all(input string tag, input logic so, fs, ifl, bs, rdy);
    check({tag, " serial_out"},  serial_out,     so);
    check({tag, " frame_start"}, frame_start,    fs);
    check({tag, " idle_fill"},   idle_fill,      ifl);
    check({tag, " busy"},        busy,           bs);
    check({tag, " data_ready"},  bus.data_ready, rdy);
  endtask

  initial begin
    rst            = 1'b0;
    tx_enable      = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // single word with tx_enable rising at the accept edge
    add_bits(1, 1, 8'hA5, 8'hA5, 0, 0, 0, 1);
    add_bits(0, 0, 8'h00, 8'hA5, 1, 7, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1);
    // back-to-back 0x3C, 0xC3 then underrun idle frame
    add_bits(1, 1, 8'h3C, 8'h3C, 0, 0, 0, 1);
    add_bits(1, 1, 8'hC3, 8'h3C, 1, 1, 0, 1);
    add_bits(1, 0, 8'h00, 8'h3C, 2, 7, 0, 0);
    add_bits(1, 0, 8'h00, 8'hC3, 0, 7, 0, 1);
    add_bits(1, 0, 8'h00, 8'h00, 0, 7, 1, 1);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1);
    // backpressure: 0x22 shifting, 0x11 held, 0x33 waits for the boundary
    add_bits(1, 1, 8'h22, 8'h22, 0, 0, 0, 1);
    add_bits(1, 1, 8'h11, 8'h22, 1, 1, 0, 1);
    add_bits(1, 1, 8'h33, 8'h22, 2, 7, 0, 0);
    add_bits(1, 1, 8'h33, 8'h11, 0, 0, 0, 1);
    add_bits(1, 0, 8'h00, 8'h11, 1, 7, 0, 0);
    add_bits(1, 0, 8'h00, 8'h33, 0, 7, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1);
    // stop at cnt==3, held 0x5A goes first after re-enable
    add_bits(1, 1, 8'h0F, 8'h0F, 0, 0, 0, 1);
    add_bits(1, 1, 8'h5A, 8'h0F, 1, 1, 0, 1);
    add_bits(1, 0, 8'h00, 8'h0F, 2, 3, 0, 0);
    add_bits(0, 0, 8'h00, 8'h0F, 4, 7, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 0);
    add_bits(1, 0, 8'h00, 8'h5A, 0, 7, 0, 1);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      tx_enable      = vq[i].te;
      bus.data_valid = vq[i].v;
      bus.data_in    = vq[i].d;
      #1;
      check($sformatf("v%0d data_ready", i), bus.data_ready, vq[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d serial_out", i),  serial_out,  vq[i].so);
      check($sformatf("v%0d frame_start", i), frame_start, vq[i].fs);
      check($sformatf("v%0d idle_fill", i),   idle_fill,   vq[i].ifl);
      check($sformatf("v%0d busy", i),        busy,        vq[i].bs);
    end

    // async reset mid-frame with a word in hold; hold must be lost
    tx_enable      = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hFF;
    @(posedge clk); #1;
    bus.data_in    = 8'hEE;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    tx_enable      = 1'b0;
    @(posedge clk); #1;
    check("pre-reset serial_out", serial_out, 1'b1);
    check("pre-reset busy", busy, 1'b1);
    check("pre-reset data_ready", bus.data_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_all("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_all("in reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst       = 1'b1;
    tx_enable = 1'b1;
    #1;
    check("post-reset data_ready", bus.data_ready, 1'b1);
    @(posedge clk); #1;
    check_all("post-reset frame", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tx_enable = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("final busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/sb_serializer.md
# sb_serializer

Sideband transmit serializer. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, LSB first, in back-to-back WIDTH-cycle frames. When no word is available at a frame boundary it fills the frame with a programmable idle word. It sits between the sideband transaction/ordered-set generator and the sideband TX pin, and is the transmit-side counterpart of the sideband `deserializer`.

## Interface
- WIDTH, 8: word and frame length in bits (≥2).
- IDLE_WORD, {WIDTH{1'b0}}: word transmitted when a frame starts with no data available.

- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- tx_enable  input  1  level; starts transmission, and stops it at the next frame boundary when low.
- data_in  input  WIDTH  word to send.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  block accepts data_in at this edge.
- serial_out  output  1  serial bit; a register bit, no combinational path from inputs.
- frame_start  output  1  high during bit 0 of every transmitted frame.
- idle_fill  output  1  high during the whole frame when that frame carries IDLE_WORD.
- busy  output  1  state == ACTIVE.

## Operation
- Storage:
  - shreg[WIDTH-1:0], with serial_out = shreg[0].
  - bit counter cnt[$clog2(WIDTH)-1:0].
  - 1-entry hold register plus a hold_full flag.
  - fill flag.
- State machine: IDLE, ACTIVE.
- Reset values: state IDLE, shreg 0, cnt 0, hold empty, fill 0. Outputs: serial_out 0, frame_start 0, idle_fill 0, busy 0, data_ready 1.
- load is true when (IDLE && tx_enable) or (ACTIVE && cnt==WIDTH-1 && tx_enable).
- Next word on load, in priority order:
  - hold contents, if hold_full;
  - otherwise data_in, if data_valid (bypass);
  - otherwise IDLE_WORD, with fill set to 1.
- data_ready = !hold_full || load.
- Accept = data_valid && data_ready at the clock edge.
- Accepted word routing:
  - if it was not consumed by the bypass, it is written into hold;
  - if hold was full and is being loaded at the same edge, the new word replaces it in hold (hold stays full).
- IDLE:
  - shreg held at 0, so serial_out is 0.
  - Words may be accepted into hold while tx_enable is low.
  - On load: state becomes ACTIVE, shreg gets the next word, cnt becomes 0.
- ACTIVE, not last bit: each edge shreg shifts right (shreg >> 1) and cnt increments.
- ACTIVE, cnt==WIDTH-1 with tx_enable high: load, cnt becomes 0. Frames are contiguous with no gap bit.
- ACTIVE, cnt==WIDTH-1 with tx_enable low: state becomes IDLE, shreg and cnt cleared. Hold contents are preserved.
- tx_enable falling mid-frame: the current frame always completes all WIDTH bits.
- Status outputs: frame_start = busy && cnt==0; idle_fill = busy && fill.
- Reset asserted mid-frame: all state is cleared immediately and asynchronously, and any hold contents are lost.

## Timing
- Bit k of a loaded word (k = 0..WIDTH-1) is on serial_out in the k-th cycle after the load edge, i.e. while cnt==k.
- Latency with bypass: a word accepted at the load edge drives its bit 0 in the very next cycle.
- Sustained throughput is one word per WIDTH cycles. data_ready is high for at least one edge per frame (the load edge) even when hold is full.
- After tx_enable rises in IDLE, the first bit appears one cycle after the next clock edge.
- The first cycle after returning to IDLE shows serial_out=0 and busy=0.
- Reset release is synchronous in effect: the first edge after rst goes high is treated as a normal edge.

## Structure
- Package sb_pkg:
  - state enum sb_ser_state_t {IDLE, ACTIVE};
  - SB_WIDTH = 8;
  - SB_IDLE_WORD default.
- One sub-module is natural: sb_tx_hold, the 1-entry buffer with the valid/ready, bypass and replace logic. The shift register, counter and FSM stay in sb_serializer.

## Test plan
- Reset: drive rst low mid-frame, then release -> all outputs are at their reset values, serial_out stays 0, data_ready=1.
- Single word, WIDTH=8: data_in=0xA5 accepted with tx_enable rising at the same edge -> serial_out = 1,0,1,0,0,1,0,1 on the next 8 cycles, frame_start in the first of them, idle_fill=0.
- Back-to-back: stream 0x3C then 0xC3 with tx_enable held high -> 16 contiguous bits 0,0,1,1,1,1,0,0, 1,1,0,0,0,0,1,1 with no gap, and frame_start every 8 cycles.
- Underrun: tx_enable high with no data_valid -> frames carry IDLE_WORD=0x00, idle_fill=1 for the full 8 cycles, busy=1.
- Backpressure: hold 0x11 in hold while frame 0x22 is shifting, offer 0x33 -> data_ready=0 until the boundary, where 0x11 is loaded and 0x33 is accepted into hold in the same cycle, so the order 0x22, 0x11, 0x33 is preserved.
- Stop: drop tx_enable at cnt==3 -> bits 4..7 are still sent, then serial_out=0 and busy=0; a word still in hold is sent first after tx_enable re-rises.
